ysyx_23060187_isu: RTL and testbench
====================================

YSYX_23060187_ISU -- requirements
Module: ysyx_23060187_ISU

Interface
REQ-001 SHALL have parameter DEPTH, default 2, buffer entries (fixed at 2 for this release).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  decode presents an instruction.
REQ-005 SHALL have port in_ready  output  1  ISU can accept an instruction this cycle.
REQ-006 SHALL have port in_aluctrl  input  4  ALU operation code.
REQ-007 SHALL have port in_rs1  input  32  rs1 register value.
REQ-008 SHALL have port in_rs2  input  32  rs2 register value.
REQ-009 SHALL have port in_pc  input  32  instruction PC.
REQ-010 SHALL have port in_imm  input  32  sign-extended immediate.
REQ-011 SHALL have port in_sel1  input  1  0: op1=rs1, 1: op1=pc.
REQ-012 SHALL have port in_sel2  input  1  0: op2=rs2, 1: op2=imm.
REQ-013 SHALL have port in_rd  input  5  destination register.
REQ-014 SHALL have port in_wen  input  1  register write enable.
REQ-015 SHALL have port flush  input  1  discard all buffered instructions.
REQ-016 SHALL have port out_valid  output  1  head entry valid toward ALU.
REQ-017 SHALL have port out_ready  input  1  execute stage consumes head.
REQ-018 SHALL have ports out_aluctrl/out_op1/out_op2/out_rd/out_wen  output  4/32/32/5/1  ALUctrl, opnum1, opnum2, rd, wen to execute.
REQ-019 SHALL have port out_illegal  output  1  head ALUctrl outside 0..6.

Function
REQ-020 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-021 in_ready SHALL be 1 iff occupancy < 2; a full buffer accepts no push even when popping the same cycle.
REQ-022 out_valid SHALL be 1 iff occupancy != 0; outputs come from head-entry registers only (no combinational in->out path).
REQ-023 Latency: instruction pushed in cycle N SHALL appear on out_valid in cycle N+1 if buffer was empty; throughput 1/cycle while out_ready=1.
REQ-024 Operand select at push: op1 = sel1 ? pc : rs1; op2 = sel2 ? imm : rs2.
REQ-025 For aluctrl 3 (SLL) and 4 (SRL), stored op2 SHALL be zero-extended op2[4:0]; all other codes store op2 unmodified.
REQ-026 out_illegal SHALL be 1 when head aluctrl > 6; entry still issues normally with wen forced to 0.
REQ-027 Order SHALL be FIFO; simultaneous push and pop at occupancy 1 keeps occupancy 1 with new entry at head next cycle.
REQ-028 flush SHALL set occupancy to 0 next cycle, overriding any same-cycle push or pop; in_ready=1 the cycle after.
REQ-029 Output fields when out_valid=0 SHALL hold their last value; not checked by bench.
REQ-030 Occupancy SHALL never exceed 2 or go below 0; pointers wrap modulo 2.

Reset
REQ-031 rst SHALL clear occupancy and pointers; next cycle out_valid=0, in_ready=1, out_illegal=0.
REQ-032 rst SHALL zero out_aluctrl, out_op1, out_op2, out_rd, out_wen.
REQ-033 rst asserted mid-stream SHALL drop all buffered instructions; rst has priority over flush, push and pop.

Structure
REQ-034 ALUctrl encodings (AND=0, OR=1, ADD=2, SLL=3, SRL=4, XOR=5, SUB=6), ALUCTRL_MAX=6 and entry field widths SHALL live in shared package ysyx_23060187_pkg.
REQ-035 Storage SHALL be one sub-module ysyx_23060187_skidbuf (2-entry valid/ready FIFO with flush); operand select and shift masking stay in ISU top.

Verification
REQ-036 Reset, then push ADD rs1=5 rs2=7 sel=00 with out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, aluctrl=2.
REQ-037 out_ready=0, push 3 instructions back-to-back -> in_ready=0 after second accepted; third held; release out_ready -> outputs appear in order 1,2,3.
REQ-038 Push SLL rs1=1 rs2=0x00000023 -> out_op2=0x00000003; push ADDI sel2=1 imm=0xFFFFFFFF -> out_op2=0xFFFFFFFF.
REQ-039 Buffer full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input not stored.
REQ-040 Push aluctrl=9 wen=1 rd=3 -> out_illegal=1, out_wen=0, out_rd=3.
REQ-041 Random push/pop/flush 10k cycles against scoreboard model -> zero order, data or occupancy mismatches.

Source files
------------

// File: rtl/ysyx_23060187_pkg.sv
// Shared ISU definitions: ALU operation codes, field widths, buffer entry layout.
// No logic state; helpers are pure combinational functions.
// Used by the issue unit top and its storage buffer.
package ysyx_23060187_pkg;

  localparam int XLEN      = 32;
  localparam int ALUCTRL_W = 4;
  localparam int RD_W      = 5;
  localparam int SHAMT_W   = 5;

  typedef enum logic [ALUCTRL_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SUB = 4'd6
  } aluctrl_e;

  localparam logic [ALUCTRL_W-1:0] ALUCTRL_MAX = 4'd6;

  // One issued instruction as seen by the execute stage.
  typedef struct packed {
    logic [ALUCTRL_W-1:0] aluctrl;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [RD_W-1:0]      rd;
    logic                 wen;
  } entry_t;

  function automatic logic is_illegal(input logic [ALUCTRL_W-1:0] code);
    return code > ALUCTRL_MAX;
  endfunction

  function automatic logic is_shift(input logic [ALUCTRL_W-1:0] code);
    return (code == ALUCTRL_W'(ALU_SLL)) || (code == ALUCTRL_W'(ALU_SRL));
  endfunction

endpackage

// File: rtl/ysyx_23060187_skidbuf.sv
// Two-entry valid/ready FIFO holding formed ISU entries, with a one-cycle flush.
// Latency: push in cycle N is visible at the head in cycle N+1; outputs are registered.
// Backpressure: in_ready drops when full (no push-through on a same-cycle pop).
module ysyx_23060187_skidbuf
  import ysyx_23060187_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            push;
  logic            pop;

  assign in_ready  = count < (PW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_data  = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties the buffer but keeps the head contents visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060187_isu.sv
// Issue unit: selects ALU operands, masks shift amounts, buffers entries toward execute.
// Latency: one cycle from accepted input to out_valid when empty; 1 instruction/cycle sustained.
// Backpressure: in_ready low while two entries are held; out_ready stalls the head.
module ysyx_23060187_isu
  import ysyx_23060187_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALUCTRL_W-1:0] in_aluctrl,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_sel1,
  input  logic                 in_sel2,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_wen,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUCTRL_W-1:0] out_aluctrl,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [RD_W-1:0]      out_rd,
  output logic                 out_wen,
  output logic                 out_illegal
);

  entry_t new_entry;
  entry_t head;
  logic [XLEN-1:0] op2_raw;

  // Form the entry at push time: operand muxes, shift-amount masking, illegal ops never write back.
  always_comb begin
    op2_raw           = in_sel2 ? in_imm : in_rs2;
    new_entry.aluctrl = in_aluctrl;
    new_entry.op1     = in_sel1 ? in_pc : in_rs1;
    new_entry.op2     = is_shift(in_aluctrl) ? {{(XLEN-SHAMT_W){1'b0}}, op2_raw[SHAMT_W-1:0]} : op2_raw;
    new_entry.rd      = in_rd;
    new_entry.wen     = in_wen && !is_illegal(in_aluctrl);
  end

  ysyx_23060187_skidbuf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (new_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_aluctrl = head.aluctrl;
  assign out_op1     = head.op1;
  assign out_op2     = head.op2;
  assign out_rd      = head.rd;
  assign out_wen     = head.wen;
  assign out_illegal = is_illegal(head.aluctrl);

endmodule

// File: tb/tb_ysyx_23060187_isu.sv
// Bench for the issue unit: table vectors, directed multi-cycle sequences and random traffic.
// Expected entries are queued when the model accepts a push and compared at the head.
// Occupancy (in_ready/out_valid) is compared every cycle against the queue depth.
module tb_ysyx_23060187_isu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_aluctrl;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        in_sel1, in_sel2;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluctrl;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

  ysyx_23060187_isu #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluctrl(in_aluctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .in_sel1(in_sel1), .in_sel2(in_sel2), .in_rd(in_rd),
    .in_wen(in_wen), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_aluctrl(out_aluctrl), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  c;
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        wen, ill;
  } exp_t;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] rs1, rs2, pc, imm;
    logic        s1, s2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] e_op1, e_op2;
    logic        e_wen, e_ill;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of the entry formed from the current inputs.
  function automatic exp_t model_of_inputs();
    exp_t e;
    logic [31:0] b;
    b = in_sel2 ? in_imm : in_rs2;
    if (in_aluctrl == 4'd3 || in_aluctrl == 4'd4) b = b & 32'h0000_001F;
    e.c   = in_aluctrl;
    e.op1 = in_sel1 ? in_pc : in_rs1;
    e.op2 = b;
    e.rd  = in_rd;
    e.ill = (in_aluctrl >= 4'd7);
    e.wen = in_wen & ~e.ill;
    return e;
  endfunction

  function automatic exp_t tx(input int i);
    exp_t e;
    e.c = tbl[i].c; e.op1 = tbl[i].e_op1; e.op2 = tbl[i].e_op2;
    e.rd = tbl[i].rd; e.wen = tbl[i].e_wen; e.ill = tbl[i].e_ill;
    return e;
  endfunction

  task automatic apply(input int i);
    in_aluctrl = tbl[i].c;  in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2;
    in_pc = tbl[i].pc;      in_imm = tbl[i].imm; in_sel1 = tbl[i].s1;
    in_sel2 = tbl[i].s2;    in_rd = tbl[i].rd;   in_wen = tbl[i].wen;
  endtask

  // One clock: compare occupancy and head, advance the model, then step past the edge.
  task automatic tick(input exp_t e);
    bit push, pop;
    chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0 && out_valid) begin
      chk("head_aluctrl", 32'(out_aluctrl), 32'(sb[0].c));
      chk("head_op1", out_op1, sb[0].op1);
      chk("head_op2", out_op2, sb[0].op2);
      chk("head_rd", 32'(out_rd), 32'(sb[0].rd));
      chk("head_wen", 32'(out_wen), 32'(sb[0].wen));
      chk("head_illegal", 32'(out_illegal), 32'(sb[0].ill));
    end
    push = in_valid && (sb.size() < 2) && !flush;
    pop  = (sb.size() != 0) && out_ready && !flush;
    @(posedge clk);
    #1;
    if (rst || flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(e);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, "_aluctrl"}, 32'(out_aluctrl), 32'd0);
    chk({tag, "_op1"}, out_op1, 32'd0);
    chk({tag, "_op2"}, out_op2, 32'd0);
    chk({tag, "_rd"}, 32'(out_rd), 32'd0);
    chk({tag, "_wen"}, 32'(out_wen), 32'd0);
  endtask

  exp_t none;

  initial begin
    //           c      rs1           rs2           pc            imm           s1    s2    rd     wen   e_op1         e_op2         e_wen e_ill
    tbl[0]  = '{4'd2,  32'd5,        32'd7,        32'h100,      32'd0,        1'b0, 1'b0, 5'd1,  1'b1, 32'd5,        32'd7,        1'b1, 1'b0};
    tbl[1]  = '{4'd3,  32'd1,        32'h23,       32'h104,      32'd0,        1'b0, 1'b0, 5'd2,  1'b1, 32'd1,        32'h3,        1'b1, 1'b0};
    tbl[2]  = '{4'd2,  32'ha,        32'd0,        32'h108,      32'hFFFFFFFF, 1'b0, 1'b1, 5'd3,  1'b1, 32'ha,        32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[3]  = '{4'd9,  32'h11,       32'h22,       32'h10c,      32'd0,        1'b0, 1'b0, 5'd3,  1'b1, 32'h11,       32'h22,       1'b0, 1'b1};
    tbl[4]  = '{4'd2,  32'd0,        32'd0,        32'h80000000, 32'h1000,     1'b1, 1'b1, 5'd4,  1'b1, 32'h80000000, 32'h1000,     1'b1, 1'b0};
    tbl[5]  = '{4'd4,  32'hF0F0F0F0, 32'd0,        32'd0,        32'hFFFFFFE5, 1'b0, 1'b1, 5'd5,  1'b1, 32'hF0F0F0F0, 32'h5,        1'b1, 1'b0};
    tbl[6]  = '{4'd6,  32'd9,        32'd4,        32'd0,        32'd0,        1'b0, 1'b0, 5'd6,  1'b1, 32'd9,        32'd4,        1'b1, 1'b0};
    tbl[7]  = '{4'd7,  32'd1,        32'd2,        32'd0,        32'd0,        1'b0, 1'b0, 5'd7,  1'b1, 32'd1,        32'd2,        1'b0, 1'b1};
    tbl[8]  = '{4'd3,  32'd0,        32'd0,        32'h200,      32'h40,       1'b1, 1'b1, 5'd8,  1'b0, 32'h200,      32'd0,        1'b0, 1'b0};
    tbl[9]  = '{4'd5,  32'h12345678, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 1'b0, 5'd31, 1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[10] = '{4'd0,  32'd3,        32'hDEADBEEF, 32'd0,        32'd0,        1'b0, 1'b0, 5'd0,  1'b1, 32'd3,        32'hDEADBEEF, 1'b1, 1'b0};
    tbl[11] = '{4'd15, 32'd4,        32'h3F,       32'd0,        32'd0,        1'b0, 1'b0, 5'd9,  1'b1, 32'd4,        32'h3F,       1'b0, 1'b1};
    none = '{4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero_outputs("reset");

    // Table: streamed back-to-back with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      apply(i);
      in_valid = 1'b1;
      tick(tx(i));
    end
    in_valid = 1'b0;
    repeat (2) tick(none);

    // Stalled execute: third instruction waits until space frees up, order preserved.
    out_ready = 1'b0;
    apply(0); in_valid = 1'b1; tick(tx(0));
    apply(1); tick(tx(1));
    apply(2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) tick(tx(2));
    out_ready = 1'b1;
    repeat (2) tick(tx(2));
    in_valid = 1'b0;
    repeat (3) tick(none);

    // Flush on a full buffer discards everything including the same-cycle input.
    out_ready = 1'b0;
    apply(3); in_valid = 1'b1; tick(tx(3));
    apply(4); tick(tx(4));
    apply(5); flush = 1'b1; tick(tx(5));
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    apply(6); in_valid = 1'b1; out_ready = 1'b1; tick(tx(6));
    in_valid = 1'b0;
    repeat (2) tick(none);

    // Reset mid-stream drops buffered entries and zeroes the head.
    out_ready = 1'b0;
    apply(7); in_valid = 1'b1; tick(tx(7));
    apply(8); tick(tx(8));
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; tick(tx(9));
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk_zero_outputs("midrst");

    // Random push/pop/flush traffic against the queue model.
    for (int n = 0; n < 10000; n++) begin
      rst        = ($urandom_range(0, 999) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_aluctrl = 4'($urandom_range(0, 15));
      in_rs1     = $urandom;
      in_rs2     = $urandom;
      in_pc      = $urandom;
      in_imm     = $urandom;
      in_sel1    = 1'($urandom_range(0, 1));
      in_sel2    = 1'($urandom_range(0, 1));
      in_rd      = 5'($urandom_range(0, 31));
      in_wen     = 1'($urandom_range(0, 1));
      tick(model_of_inputs());
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick(none);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
